// File: rtl/issue_window.sv
// issue_window: in-order circular issue queue feeding the scoreboard with a WIDTH-slot window.
// Ports: clk/rst (sync, active-high) and flush; in_* is the decode group (in_ready gates acceptance);
// win_* is the oldest-WIDTH window sent to the scoreboard, which answers with can_issue;
// iss_* is the issued in-order prefix sent to execute; occupancy is the registered entry count.
module issue_window #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 16,
    parameter int RD_WIDTH    = 5,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [0:WIDTH-1]       in_valid,
    input  logic [INSTR_WIDTH-1:0] in_instr     [0:WIDTH-1],
    input  logic [RD_WIDTH-1:0]    in_rd        [0:WIDTH-1],
    input  logic [RD_WIDTH-1:0]    in_rs1       [0:WIDTH-1],
    input  logic [RD_WIDTH-1:0]    in_rs2       [0:WIDTH-1],
    input  logic [0:WIDTH-1]       in_rd_valid,
    input  logic [0:WIDTH-1]       in_branch,
    output logic                   in_ready,
    output logic [0:WIDTH-1]       win_valid,
    output logic [RD_WIDTH-1:0]    win_rs1      [0:WIDTH-1],
    output logic [RD_WIDTH-1:0]    win_rs2      [0:WIDTH-1],
    input  logic [0:WIDTH-1]       can_issue,
    output logic [0:WIDTH-1]       iss_valid,
    output logic [INSTR_WIDTH-1:0] iss_instr    [0:WIDTH-1],
    output logic [RD_WIDTH-1:0]    iss_rd       [0:WIDTH-1],
    output logic [0:WIDTH-1]       iss_rd_valid,
    output logic [0:WIDTH-1]       iss_branch,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_WIDTH-1:0] m_instr [DEPTH];
    logic [RD_WIDTH-1:0]    m_rd    [DEPTH];
    logic [RD_WIDTH-1:0]    m_rs1   [DEPTH];
    logic [RD_WIDTH-1:0]    m_rs2   [DEPTH];
    logic [DEPTH-1:0]       m_rdv;
    logic [DEPTH-1:0]       m_br;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;
    logic [CW-1:0]          n_in;
    logic [CW-1:0]          n_iss;
    logic                   run;
    logic                   ok;
    logic [PW-1:0]          e;
    logic                   wr;

    assign in_ready  = count <= CW'(DEPTH - WIDTH);
    assign occupancy = count;
    assign wr        = in_ready && !flush && !rst;

    // Only the leading contiguous run of valid slots is accepted.
    always_comb begin
        run  = 1'b1;
        n_in = '0;
        for (int k = 0; k < WIDTH; k++) begin
            run  = run & in_valid[k];
            n_in = n_in + CW'(run);
        end
    end

    // Issue is a strict in-order prefix; one blocked slot stops everything younger.
    always_comb begin
        ok    = ~flush;
        n_iss = '0;
        e     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            e               = head + PW'(i);
            win_valid[i]    = CW'(i) < count;
            win_rs1[i]      = win_valid[i] ? m_rs1[e] : '0;
            win_rs2[i]      = win_valid[i] ? m_rs2[e] : '0;
            ok              = ok & win_valid[i] & can_issue[i];
            iss_valid[i]    = ok;
            n_iss           = n_iss + CW'(ok);
            iss_instr[i]    = ok ? m_instr[e] : '0;
            iss_rd[i]       = ok ? m_rd[e] : '0;
            iss_rd_valid[i] = ok & m_rdv[e];
            iss_branch[i]   = ok & m_br[e];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + n_iss[PW-1:0];
            tail  <= tail + (in_ready ? n_in[PW-1:0] : '0);
            count <= count + (in_ready ? n_in : '0) - n_iss;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (CW'(k) < n_in) begin
                    m_instr[tail + PW'(k)] <= in_instr[k];
                    m_rd[tail + PW'(k)]    <= in_rd[k];
                    m_rs1[tail + PW'(k)]   <= in_rs1[k];
                    m_rs2[tail + PW'(k)]   <= in_rs2[k];
                    m_rdv[tail + PW'(k)]   <= in_rd_valid[k];
                    m_br[tail + PW'(k)]    <= in_branch[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_issue_window.sv
// tb_issue_window: directed self-checking bench for issue_window.
module tb_issue_window;
    localparam int W  = 4;
    localparam int D  = 16;
    localparam int RW = 5;
    localparam int IW = 32;

    logic clk = 1'b0;
    logic rst, flush, in_ready;
    logic [0:W-1] in_valid, in_rd_valid, in_branch, win_valid, can_issue, iss_valid, iss_rd_valid, iss_branch;
    logic [IW-1:0] in_instr [0:W-1];
    logic [IW-1:0] iss_instr [0:W-1];
    logic [RW-1:0] in_rd [0:W-1];
    logic [RW-1:0] in_rs1 [0:W-1];
    logic [RW-1:0] in_rs2 [0:W-1];
    logic [RW-1:0] win_rs1 [0:W-1];
    logic [RW-1:0] win_rs2 [0:W-1];
    logic [RW-1:0] iss_rd [0:W-1];
    logic [4:0] occupancy;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    issue_window #(.WIDTH(W), .DEPTH(D), .RD_WIDTH(RW), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd_valid(in_rd_valid), .in_branch(in_branch), .in_ready(in_ready),
        .win_valid(win_valid), .win_rs1(win_rs1), .win_rs2(win_rs2), .can_issue(can_issue),
        .iss_valid(iss_valid), .iss_instr(iss_instr), .iss_rd(iss_rd),
        .iss_rd_valid(iss_rd_valid), .iss_branch(iss_branch), .occupancy(occupancy)
    );

    task automatic load(input logic [0:W-1] v, input int base);
        in_valid = v;
        for (int k = 0; k < W; k++) begin
            in_instr[k] = IW'(base + k);
            in_rd[k]    = RW'(k + 1);
            in_rs1[k]   = RW'(k + 5);
            in_rs2[k]   = RW'(k + 10);
        end
        in_rd_valid = 4'b1101;
        in_branch   = 4'b0100;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        flush = 1'b0;
        can_issue = 4'b1111;
        load(4'b0000, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (win_valid !== 4'b0000) begin failures++; $display("FAIL reset_win got=%b exp=0000", win_valid); end
        checks++; if (iss_valid !== 4'b0000) begin failures++; $display("FAIL reset_iss got=%b exp=0000", iss_valid); end
        for (int k = 0; k < W; k++) begin
            checks++;
            if (win_rs1[k] !== '0 || win_rs2[k] !== '0 || iss_instr[k] !== '0 || iss_rd[k] !== '0) begin
                failures++; $display("FAIL reset_fields slot=%0d got=%0h/%0h/%0h/%0h exp=0", k, win_rs1[k], win_rs2[k], iss_instr[k], iss_rd[k]);
            end
        end
        checks++; if ({iss_rd_valid, iss_branch} !== 8'h00) begin failures++; $display("FAIL reset_flags got=%b%b exp=0", iss_rd_valid, iss_branch); end
    endtask

    task automatic test_enq4;
        can_issue = 4'b1111;
        load(4'b1111, 100);
        #1;
        checks++; if (iss_valid !== 4'b0000) begin failures++; $display("FAIL enq4_empty_iss got=%b exp=0000", iss_valid); end
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        checks++; if (win_valid !== 4'b1111) begin failures++; $display("FAIL enq4_win got=%b exp=1111", win_valid); end
        checks++; if (iss_valid !== 4'b1111) begin failures++; $display("FAIL enq4_iss got=%b exp=1111", iss_valid); end
        for (int k = 0; k < W; k++) begin
            checks++;
            if (iss_instr[k] !== IW'(100 + k) || iss_rd[k] !== RW'(k + 1) || win_rs1[k] !== RW'(k + 5) || win_rs2[k] !== RW'(k + 10)) begin
                failures++; $display("FAIL enq4_slot%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", k,
                    iss_instr[k], iss_rd[k], win_rs1[k], win_rs2[k], 100 + k, k + 1, k + 5, k + 10);
            end
        end
        checks++; if (iss_rd_valid !== 4'b1101) begin failures++; $display("FAIL enq4_rdv got=%b exp=1101", iss_rd_valid); end
        checks++; if (iss_branch !== 4'b0100) begin failures++; $display("FAIL enq4_br got=%b exp=0100", iss_branch); end
        @(negedge clk);
        #1;
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL enq4_drained got=%0d exp=0", occupancy); end
        checks++; if (win_valid !== 4'b0000) begin failures++; $display("FAIL enq4_win_empty got=%b exp=0000", win_valid); end
    endtask

    task automatic test_partial;
        can_issue = 4'b0111;
        load(4'b1011, 200);
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL part_occ got=%0d exp=1", occupancy); end
        checks++; if (win_valid !== 4'b1000) begin failures++; $display("FAIL part_win got=%b exp=1000", win_valid); end
        checks++; if (iss_valid !== 4'b0000) begin failures++; $display("FAIL part_iss got=%b exp=0000", iss_valid); end
        checks++; if (iss_rd_valid !== 4'b0000) begin failures++; $display("FAIL part_rdv got=%b exp=0000", iss_rd_valid); end
        checks++; if (iss_instr[0] !== '0 || iss_rd[0] !== '0) begin failures++; $display("FAIL part_gated got=%0d/%0d exp=0/0", iss_instr[0], iss_rd[0]); end
        checks++; if (win_rs1[0] !== RW'(5) || win_rs1[1] !== '0) begin failures++; $display("FAIL part_rs1 got=%0d/%0d exp=5/0", win_rs1[0], win_rs1[1]); end
        can_issue = 4'b1111;
        #1;
        checks++; if (iss_valid !== 4'b1000) begin failures++; $display("FAIL part_iss1 got=%b exp=1000", iss_valid); end
        checks++; if (iss_instr[0] !== IW'(200)) begin failures++; $display("FAIL part_instr got=%0d exp=200", iss_instr[0]); end
        @(negedge clk);
        #1;
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL part_drained got=%0d exp=0", occupancy); end
    endtask

    task automatic test_full;
        can_issue = 4'b0000;
        load(4'b1111, 300);
        @(negedge clk);
        load(4'b1111, 304);
        @(negedge clk);
        load(4'b1111, 308);
        @(negedge clk);
        load(4'b1000, 312);
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        checks++; if (occupancy !== 5'd13) begin failures++; $display("FAIL full_occ got=%0d exp=13", occupancy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        load(4'b1111, 900);
        can_issue = 4'b1100;
        #1;
        checks++; if (iss_valid !== 4'b1100) begin failures++; $display("FAIL full_iss got=%b exp=1100", iss_valid); end
        checks++; if (iss_instr[1] !== IW'(301)) begin failures++; $display("FAIL full_instr got=%0d exp=301", iss_instr[1]); end
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        checks++; if (occupancy !== 5'd11) begin failures++; $display("FAIL full_occ11 got=%0d exp=11", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready1 got=%b exp=1", in_ready); end
        can_issue = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (iss_valid !== (c < 2 ? 4'b1111 : 4'b1110) || iss_instr[0] !== IW'(302 + 4 * c)) begin
                failures++; $display("FAIL full_drain%0d got=%b/%0d exp=%b/%0d", c, iss_valid, iss_instr[0], c < 2 ? 4'b1111 : 4'b1110, 302 + 4 * c);
            end
            @(negedge clk);
        end
        #1;
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", occupancy); end
    endtask

    task automatic test_wrap;
        int last;
        last = -1;
        can_issue = 4'b1111;
        for (int c = 0; c <= 14; c++) begin
            if (c < 14) load(4'b1110, 3 * c);
            else in_valid = 4'b0000;
            #1;
            checks++;
            if (iss_valid !== (c == 0 ? 4'b0000 : 4'b1110)) begin
                failures++; $display("FAIL wrap_iss cyc=%0d got=%b exp=%b", c, iss_valid, c == 0 ? 4'b0000 : 4'b1110);
            end
            if (c > 0) begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (iss_instr[k] !== IW'(3 * (c - 1) + k) || int'(iss_instr[k]) <= last) begin
                        failures++; $display("FAIL wrap_seq cyc=%0d slot=%0d got=%0d exp=%0d", c, k, iss_instr[k], 3 * (c - 1) + k);
                    end
                    last = 3 * (c - 1) + k;
                end
            end
            @(negedge clk);
        end
        #1;
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL wrap_drained got=%0d exp=0", occupancy); end
    endtask

    task automatic test_flush;
        can_issue = 4'b0000;
        load(4'b1111, 400);
        @(negedge clk);
        load(4'b1100, 404);
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        checks++; if (occupancy !== 5'd6) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=6", occupancy); end
        flush = 1'b1;
        load(4'b1111, 450);
        can_issue = 4'b1111;
        #1;
        checks++; if (iss_valid !== 4'b0000) begin failures++; $display("FAIL flush_iss got=%b exp=0000", iss_valid); end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 4'b0000;
        #1;
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        checks++; if (win_valid !== 4'b0000) begin failures++; $display("FAIL flush_win got=%b exp=0000", win_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        load(4'b1000, 500);
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        checks++; if (iss_valid !== 4'b1000 || iss_instr[0] !== IW'(500)) begin failures++; $display("FAIL flush_after got=%b/%0d exp=1000/500", iss_valid, iss_instr[0]); end
        @(negedge clk);
        #1;
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL flush_end got=%0d exp=0", occupancy); end
    endtask

    initial begin
        test_reset;
        test_enq4;
        test_partial;
        test_full;
        test_wrap;
        test_flush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
